// File: rtl/nonce_dispatcher_pkg.sv
// Shared widths, constants and the dispatcher state type for the SHA core array control path.
package sha_pkg;
  localparam int                 CYCLE_W    = 6;
  localparam logic [CYCLE_W-1:0] LAST_CYCLE = 6'd63;
  localparam int                 NONCE_W    = 32;
  localparam int                 RESULT_W   = NONCE_W + 1;
  localparam int                 FLAG_BIT   = NONCE_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } disp_state_e;
endpackage

// File: rtl/nonce_dispatcher_if.sv
// Host-side job control and found-nonce valid/ready channel of the nonce dispatcher.
interface nonce_dispatcher_if;
  import sha_pkg::*;

  logic               start;
  logic [NONCE_W-1:0] start_nonce;
  logic               abort;
  logic               busy;
  logic               done;
  logic               res_valid;
  logic [NONCE_W-1:0] res_nonce;
  logic               res_ready;
  logic               overflow;

  modport master (
    output start, start_nonce, abort, res_ready,
    input  busy, done, res_valid, res_nonce, overflow
  );

  modport slave (
    input  start, start_nonce, abort, res_ready,
    output busy, done, res_valid, res_nonce, overflow
  );
endinterface

// File: rtl/nonce_dispatcher_result_fifo.sv
// Small flop-based FIFO; the head is a register so the consumer sees no combinational path from pop.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A push into a full queue is still taken when the head leaves on the same edge.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_d;
    assign entry_d = (wr_en && (wr_ptr_q == AW'(gi))) ? push_data : mem_q[gi];
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) mem_q[gi] <= '0;
      else        mem_q[gi] <= entry_d;
    end
  end
endmodule

// File: rtl/nonce_dispatcher.sv
// Round sequencer and found-nonce collector for the SHA core array.
// Define DISPATCH_STATS_EN to add the rounds_done completed-round counter output.
module nonce_dispatcher
  import sha_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  nonce_dispatcher_if.slave             host,
  output logic [CYCLE_W-1:0]            cycle,
  output logic [NONCE_W-1:0]            nonce,
  output logic [NUM_CORES*NONCE_W-1:0]  nonce_factor,
`ifdef DISPATCH_STATS_EN
  output logic [31:0]                   rounds_done,
`endif
  input  logic [NUM_CORES*RESULT_W-1:0] core_result
);
  disp_state_e          state_q, state_d;
  logic [CYCLE_W-1:0]   cycle_q, cycle_d;
  logic [NONCE_W-1:0]   nonce_q, nonce_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [NONCE_W-1:0]   latched_q [NUM_CORES];
  logic [NUM_CORES-1:0] flags;
  logic [NUM_CORES-1:0] drain_mask;
  logic [NONCE_W:0]     nonce_sum;
  logic [NONCE_W-1:0]   push_data;
  logic                 push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                 abort_edge, capture;

  assign abort_edge = (state_q == RUN) && host.abort;
  assign capture    = (state_q == RUN) && !host.abort && (cycle_q == LAST_CYCLE);
  assign nonce_sum  = {1'b0, nonce_q} + (NONCE_W+1)'(NUM_CORES);

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    logic [NONCE_W-1:0] latched_d;
    assign flags[gi] = core_result[gi*RESULT_W + FLAG_BIT];
    assign nonce_factor[gi*NONCE_W +: NONCE_W] = NONCE_W'(gi);
    assign latched_d = (capture && flags[gi]) ? core_result[gi*RESULT_W +: NONCE_W]
                                              : latched_q[gi];
    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) latched_q[gi] <= '0;
      else        latched_q[gi] <= latched_d;
    end
  end

  // Lowest-index pending core wins; scanning downward lets the last hit stand.
  always_comb begin
    push_req   = 1'b0;
    push_data  = '0;
    drain_mask = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_req      = 1'b1;
        push_data     = latched_q[i];
        drain_mask    = '0;
        drain_mask[i] = 1'b1;
      end
    end
  end

  assign fifo_pop  = host.res_ready && !fifo_empty;
  assign fifo_push = push_req && !abort_edge;

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    nonce_d    = nonce_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    pending_d  = pending_q & ~drain_mask;
    case (state_q)
      IDLE: begin
        cycle_d = '0;
        if (host.start) begin
          nonce_d    = host.start_nonce;
          overflow_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (host.abort) begin
          state_d   = IDLE;
          cycle_d   = '0;
          pending_d = '0;
        end else if (cycle_q == LAST_CYCLE) begin
          pending_d = pending_d | flags;
          cycle_d   = '0;
          nonce_d   = nonce_sum[NONCE_W-1:0];
          if (nonce_sum[NONCE_W]) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cycle_d = cycle_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cycle_q    <= '0;
      nonce_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      pending_q  <= '0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      nonce_q    <= nonce_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
    end
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NONCE_W)
  ) u_result_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (host.res_nonce),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef DISPATCH_STATS_EN
  logic [31:0] rounds_q, rounds_d;
  always_comb begin
    rounds_d = rounds_q;
    if (state_q == IDLE && host.start) rounds_d = '0;
    else if (capture)                  rounds_d = rounds_q + 1'b1;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rounds_q <= '0;
    else        rounds_q <= rounds_d;
  end
  assign rounds_done = rounds_q;
`endif

  assign cycle          = cycle_q;
  assign nonce          = nonce_q;
  assign host.busy      = (state_q == RUN);
  assign host.done      = done_q;
  assign host.overflow  = overflow_q;
  assign host.res_valid = !fifo_empty;
endmodule

// File: tb/tb_nonce_dispatcher.sv
// Directed self-checking bench for nonce_dispatcher (NUM_CORES=4, FIFO_DEPTH=4).
module tb_nonce_dispatcher;
  import sha_pkg::*;

  localparam int NC = 4;
  localparam int FD = 4;

  logic               clk = 1'b0;
  logic               n_rst;
  logic [5:0]         cycle;
  logic [31:0]        nonce;
  logic [NC*32-1:0]   nonce_factor;
  logic [NC*33-1:0]   core_result;
`ifdef DISPATCH_STATS_EN
  logic [31:0]        rounds_done;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nonce_dispatcher_if host_if();

  nonce_dispatcher #(.NUM_CORES(NC), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .host         (host_if),
    .cycle        (cycle),
    .nonce        (nonce),
    .nonce_factor (nonce_factor),
`ifdef DISPATCH_STATS_EN
    .rounds_done  (rounds_done),
`endif
    .core_result  (core_result)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_last();
    int n = 0;
    while (cycle !== 6'd63 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (cycle !== 6'd63) begin
      errors++;
      $display("FAIL run_to_last: cycle=%0d required 63 within 200 clocks", cycle);
    end
  endtask

  task automatic set_flag(input int k, input logic [31:0] v);
    core_result[k*33 +: 33] = {1'b1, v};
  endtask

  task automatic start_job(input logic [31:0] sn);
    host_if.start_nonce = sn;
    host_if.start       = 1'b1;
    tick();
    host_if.start       = 1'b0;
  endtask

  task automatic abort_job();
    host_if.abort = 1'b1;
    tick();
    host_if.abort = 1'b0;
  endtask

  task automatic test_reset();
    logic [NC*32-1:0] exp_factor;
    exp_factor = {32'd3, 32'd2, 32'd1, 32'd0};
    n_rst = 1'b0;
    #12;
    checks++; if (cycle !== 6'd0) begin errors++; $display("FAIL reset_cycle: got %0d required 0", cycle); end
    checks++; if (nonce !== 32'h0) begin errors++; $display("FAIL reset_nonce: got %h required 0", nonce); end
    checks++; if (host_if.busy !== 1'b0 || host_if.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b required 00", host_if.busy, host_if.done); end
    checks++; if (host_if.res_valid !== 1'b0 || host_if.res_nonce !== 32'h0) begin errors++; $display("FAIL reset_res: valid=%b nonce=%h required 0/0", host_if.res_valid, host_if.res_nonce); end
    checks++; if (host_if.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", host_if.overflow); end
    checks++; if (nonce_factor !== exp_factor) begin errors++; $display("FAIL nonce_factor: got %h required %h", nonce_factor, exp_factor); end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    checks++; if (host_if.busy !== 1'b0 || cycle !== 6'd0) begin errors++; $display("FAIL idle_after_reset: busy=%b cycle=%0d required 0/0", host_if.busy, cycle); end
    $display("test_reset complete");
  endtask

  task automatic test_round();
    start_job(32'h100);
    checks++; if (host_if.busy !== 1'b1 || cycle !== 6'd0 || nonce !== 32'h100) begin errors++; $display("FAIL start: busy=%b cycle=%0d nonce=%h required 1/0/100", host_if.busy, cycle, nonce); end
    run_to_last();
    tick();
    checks++; if (nonce !== 32'h104 || cycle !== 6'd0) begin errors++; $display("FAIL round_advance: nonce=%h cycle=%0d required 104/0", nonce, cycle); end
    checks++; if (host_if.busy !== 1'b1 || host_if.res_valid !== 1'b0) begin errors++; $display("FAIL round_status: busy=%b res_valid=%b required 1/0", host_if.busy, host_if.res_valid); end
    $display("test_round complete: nonce=%h", nonce);
  endtask

  task automatic test_found();
    run_to_last();
    set_flag(1, 32'h201);
    set_flag(3, 32'h203);
    host_if.res_ready = 1'b1;
    tick();
    core_result = '0;
    checks++; if (host_if.res_valid !== 1'b0) begin errors++; $display("FAIL found_at_E: res_valid=%b required 0", host_if.res_valid); end
    tick();
    checks++; if (host_if.res_valid !== 1'b1 || host_if.res_nonce !== 32'h201) begin errors++; $display("FAIL found_E1: valid=%b nonce=%h required 1/201", host_if.res_valid, host_if.res_nonce); end
    tick();
    checks++; if (host_if.res_valid !== 1'b1 || host_if.res_nonce !== 32'h203) begin errors++; $display("FAIL found_E2: valid=%b nonce=%h required 1/203", host_if.res_valid, host_if.res_nonce); end
    tick();
    checks++; if (host_if.res_valid !== 1'b0) begin errors++; $display("FAIL found_E3: res_valid=%b required 0", host_if.res_valid); end
    host_if.res_ready = 1'b0;
    abort_job();
    checks++; if (host_if.busy !== 1'b0 || host_if.done !== 1'b0) begin errors++; $display("FAIL found_abort: busy=%b done=%b required 0/0", host_if.busy, host_if.done); end
    $display("test_found complete");
  endtask

  task automatic test_exhaust();
    int pulses = 0;
    start_job(32'hFFFF_FFF8);
    run_to_last();
    tick();
    checks++; if (nonce !== 32'hFFFF_FFFC || host_if.busy !== 1'b1 || host_if.done !== 1'b0) begin errors++; $display("FAIL exhaust_r1: nonce=%h busy=%b done=%b required fffffffc/1/0", nonce, host_if.busy, host_if.done); end
    run_to_last();
    tick();
    checks++; if (host_if.done !== 1'b1 || host_if.busy !== 1'b0) begin errors++; $display("FAIL exhaust_done: done=%b busy=%b required 1/0", host_if.done, host_if.busy); end
    checks++; if (nonce !== 32'h0 || cycle !== 6'd0) begin errors++; $display("FAIL exhaust_wrap: nonce=%h cycle=%0d required 0/0", nonce, cycle); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (host_if.done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0 || nonce !== 32'h0 || host_if.busy !== 1'b0) begin errors++; $display("FAIL exhaust_after: extra_pulses=%0d nonce=%h busy=%b required 0/0/0", pulses, nonce, host_if.busy); end
    $display("test_exhaust complete");
  endtask

  task automatic test_overflow();
    host_if.res_ready = 1'b0;
    start_job(32'h0);
    run_to_last();
    for (int k = 0; k < NC; k++) set_flag(k, 32'hA0 + k);
    tick();
    core_result = '0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (host_if.overflow !== 1'b0 || host_if.res_nonce !== 32'hA0) begin errors++; $display("FAIL ovf_fill: overflow=%b head=%h required 0/a0", host_if.overflow, host_if.res_nonce); end
    run_to_last();
    set_flag(0, 32'hB0);
    set_flag(1, 32'hB1);
    tick();
    core_result = '0;
    tick();
    tick();
    checks++; if (host_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: overflow=%b required 1", host_if.overflow); end
    abort_job();
    host_if.res_ready = 1'b1;
    for (int i = 0; i < FD; i++) begin
      checks++; if (host_if.res_valid !== 1'b1 || host_if.res_nonce !== 32'hA0 + i) begin errors++; $display("FAIL ovf_drain%0d: valid=%b nonce=%h required 1/%h", i, host_if.res_valid, host_if.res_nonce, 32'hA0 + i); end
      tick();
    end
    host_if.res_ready = 1'b0;
    checks++; if (host_if.res_valid !== 1'b0 || host_if.overflow !== 1'b1) begin errors++; $display("FAIL ovf_end: valid=%b overflow=%b required 0/1", host_if.res_valid, host_if.overflow); end
    $display("test_overflow complete");
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_q [4];
    exp_q = '{32'hC1, 32'hC2, 32'hC3, 32'hD0};
    host_if.res_ready = 1'b0;
    start_job(32'h1000);
    checks++; if (host_if.overflow !== 1'b0) begin errors++; $display("FAIL start_clears_ovf: overflow=%b required 0", host_if.overflow); end
    run_to_last();
    for (int k = 0; k < NC; k++) set_flag(k, 32'hC0 + k);
    tick();
    core_result = '0;
    for (int i = 0; i < 4; i++) tick();
    run_to_last();
    set_flag(0, 32'hD0);
    tick();
    core_result = '0;
    host_if.res_ready = 1'b1;
    tick();
    checks++; if (host_if.overflow !== 1'b0 || host_if.res_nonce !== 32'hC1) begin errors++; $display("FAIL full_push_pop: overflow=%b head=%h required 0/c1", host_if.overflow, host_if.res_nonce); end
    host_if.res_ready = 1'b0;
    abort_job();
    host_if.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (host_if.res_valid !== 1'b1 || host_if.res_nonce !== exp_q[i]) begin errors++; $display("FAIL full_drain%0d: valid=%b nonce=%h required 1/%h", i, host_if.res_valid, host_if.res_nonce, exp_q[i]); end
      tick();
    end
    host_if.res_ready = 1'b0;
    checks++; if (host_if.res_valid !== 1'b0) begin errors++; $display("FAIL full_empty: valid=%b required 0", host_if.res_valid); end
    $display("test_full_pop complete");
  endtask

  task automatic test_abort();
    int pushed = 0;
    start_job(32'h300);
    run_to_last();
    set_flag(2, 32'h333);
    host_if.abort = 1'b1;
    tick();
    host_if.abort = 1'b0;
    core_result   = '0;
    checks++; if (host_if.busy !== 1'b0 || cycle !== 6'd0 || host_if.done !== 1'b0) begin errors++; $display("FAIL abort_state: busy=%b cycle=%0d done=%b required 0/0/0", host_if.busy, cycle, host_if.done); end
    checks++; if (nonce !== 32'h300) begin errors++; $display("FAIL abort_nonce: got %h required 300", nonce); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (host_if.res_valid !== 1'b0) pushed++;
    end
    checks++; if (pushed !== 0) begin errors++; $display("FAIL abort_nopush: valid seen %0d cycles required 0", pushed); end
    start_job(32'h400);
    checks++; if (host_if.busy !== 1'b1 || nonce !== 32'h400) begin errors++; $display("FAIL restart: busy=%b nonce=%h required 1/400", host_if.busy, nonce); end
    run_to_last();
    tick();
    checks++; if (nonce !== 32'h404 || host_if.res_valid !== 1'b0) begin errors++; $display("FAIL restart_round: nonce=%h valid=%b required 404/0", nonce, host_if.res_valid); end
    abort_job();
    $display("test_abort complete");
  endtask

  task automatic test_async_reset();
    start_job(32'h500);
    for (int i = 0; i < 5; i++) tick();
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if (cycle !== 6'd0 || nonce !== 32'h0 || host_if.busy !== 1'b0) begin errors++; $display("FAIL async_reset: cycle=%0d nonce=%h busy=%b required 0/0/0", cycle, nonce, host_if.busy); end
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    $display("test_async_reset complete");
  endtask

`ifdef DISPATCH_STATS_EN
  task automatic test_stats();
    start_job(32'h600);
    checks++; if (rounds_done !== 32'd0) begin errors++; $display("FAIL stats_clear: got %0d required 0", rounds_done); end
    for (int r = 0; r < 3; r++) begin
      run_to_last();
      tick();
    end
    for (int i = 0; i < 10; i++) tick();
    abort_job();
    checks++; if (rounds_done !== 32'd3) begin errors++; $display("FAIL stats_rounds: got %0d required 3", rounds_done); end
    $display("test_stats complete");
  endtask
`endif

  initial begin
    host_if.start       = 1'b0;
    host_if.start_nonce = '0;
    host_if.abort       = 1'b0;
    host_if.res_ready   = 1'b0;
    core_result         = '0;
    test_reset();
    test_round();
    test_found();
    test_exhaust();
    test_overflow();
    test_full_pop();
    test_abort();
`ifdef DISPATCH_STATS_EN
    test_stats();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nonce_dispatcher.md
# nonce_dispatcher

Control block for the SHA core array. It steps the round counter, supplies the shared nonce base and the fixed per-core nonce offsets, and collects the flag+nonce results the cores return. Found nonces are queued and sent to the host interface over a valid/ready handshake. It sits between the host job registers and the array of SHA cores; midState and headData go straight from the job registers to the cores.

## Interface
Parameters:
- NUM_CORES, 4: number of SHA cores driven (1..32).
- FIFO_DEPTH, 4: found-nonce queue depth (power of two, ≥2).

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- start_nonce  in  32  first nonce base of the job.
- abort  in  1  stop the current job.
- cycle  out  6  round counter to all cores.
- nonce  out  32  nonce base to all cores.
- nonce_factor  out  NUM_CORES*32  core k slice [32k+31:32k] = k (constant).
- core_result  in  NUM_CORES*33  core k slice [33k+32:33k]; bit 32 = found flag, [31:0] = nonce.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the nonce space is exhausted.
- res_valid  out  1  queue non-empty.
- res_nonce  out  32  head of queue.
- res_ready  in  1  host consumes head.
- overflow  out  1  sticky: a found nonce was dropped.

## Operation
- Reset: state IDLE; cycle 0, nonce 0, busy 0, done 0, res_valid 0, res_nonce 0, overflow 0, pending mask 0, queue empty.
- IDLE: cycle is held at 0. On start: nonce ← start_nonce, overflow ← 0, go to RUN. Queue contents are kept.
- RUN: cycle increments by 1 every clock, 0..63. On the edge where cycle==63 (capture edge):
  - pending ← pending | {core_result[33k+32]}; the core nonces are latched together with the flags.
  - cycle ← 0.
  - {carry, nonce} ← nonce + NUM_CORES. If carry=1: go to IDLE, done pulses for 1 cycle, nonce keeps its wrapped value.
- start in RUN is ignored. abort in RUN: go to IDLE on the next edge, cycle ← 0, pending ← 0, no done pulse. abort has priority over the capture edge. Queue contents are kept.
- Pending drain (any state): on each edge, the lowest-index set pending bit pushes its latched nonce and that bit clears.
- Push while full: the entry is dropped, its bit still clears, overflow ← 1. When push and pop happen on the same edge with the queue full, the push is accepted.
- Pop: on the edge where res_valid && res_ready.
- Arithmetic: nonce addition is modulo 2^32 with the carry detected. nonce_factor is purely constant.

## Timing
- start edge → busy=1, cycle=0, nonce=start_nonce in the next cycle.
- A round lasts exactly 64 clocks. Throughput is NUM_CORES nonces per 64 clocks.
- Capture edge E → first found nonce pushed at E+1; res_valid=1 and res_nonce valid from E+1. The k-th set flag is pushed at E+k.
- res_nonce/res_valid are registered (FIFO head). No combinational path from res_ready to res_valid.
- done is asserted in the cycle after the exhausting capture edge, together with busy=0.
- Asynchronous reset mid-job returns every output to its reset value immediately.

## Configuration
- DISPATCH_STATS_EN defined: adds output rounds_done[31:0]. It clears on start and increments on every RUN capture edge, wrapping mod 2^32. An aborted partial round is not counted.
- DISPATCH_STATS_EN undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Package sha_pkg: CYCLE_W=6, LAST_CYCLE=6'd63, NONCE_W=32, the dispatcher state enum {IDLE, RUN}, and the result slice widths (33).
- Sub-module result_fifo: synchronous FIFO, parameters DEPTH and WIDTH=32, with push/pop/full/empty. Full-and-push-with-pop is legal.
- nonce_dispatcher holds the FSM, cycle/nonce registers, pending mask, latched nonces, priority pusher and overflow flag.

## Test plan
- Reset, then start with start_nonce=0x100 and NUM_CORES=4 → after 64 clocks nonce=0x104, cycle returns 0, busy stays 1, res_valid stays 0 with no flags.
- Cores 1 and 3 flag in the same round with nonces 0x201 and 0x203, res_ready=1 → res_nonce=0x201 at E+1 and 0x203 at E+2, with no gaps.
- start_nonce=0xFFFFFFF8 → after 2 rounds done pulses once, busy=0, nonce=0x00000000, cycle=0.
- res_ready=0, FIFO_DEPTH=4, 6 flags over two rounds → 4 entries queued, overflow=1, 2 entries dropped. Draining yields the first 4 in order.
- abort asserted at cycle==63 with a flag pending → IDLE next cycle, nothing pushed, done=0, and a later start runs normally.
- With DISPATCH_STATS_EN, 3 full rounds then abort mid-round → rounds_done=3.
